b_req_responder: RTL and testbench
==================================

// Module: b_req_responder
// PURPOSE
//  Side-B responder of the A->B request link: samples Valid_Addr/Address driven by side A,
//  buffers requests, looks each address up in a local 24-bit table and returns the result on
//  Valid_Data/Data, in order, after a fixed programmable latency. Sits behind the B end of
//  A_B_req_if and replaces the behavioural B model in the bench.
// PARAMETERS
//  ADDR_W      12    request address width (matches interface)
//  DATA_W      24    response data width (matches interface)
//  FIFO_DEPTH  8     request buffer entries, power of 2, >=2
//  RESP_LAT    2     wait cycles between pop and response, >=1
// PORTS
//  clk          in   1       single clock, all logic on posedge
//  rst          in   1       asynchronous, active-high reset
//  Valid_Addr   in   1       request strobe from A, one request per high cycle
//  Address      in   ADDR_W  request address, valid with Valid_Addr
//  Valid_Data   out  1       response strobe, high exactly one cycle per response
//  Data         out  DATA_W  response payload, valid with Valid_Data, held otherwise
//  cfg_we       in   1       table write enable
//  cfg_addr     in   ADDR_W  table write address
//  cfg_wdata    in   DATA_W  table write data
//  busy         out  1       FIFO non-empty or FSM not IDLE
//  fifo_level   out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
//  drop_cnt     out  8       requests dropped on full FIFO, saturates at 255
// BEHAVIOUR
//  - Reset: Valid_Data=0, Data=0, busy=0, fifo_level=0, drop_cnt=0, FSM=IDLE, FIFO emptied.
//    Table is NOT reset; contents undefined until written. Reset mid-response discards all.
//  - No backpressure on the link: every posedge with Valid_Addr=1 pushes Address.
//  - Full FIFO: push with no same-cycle pop is dropped, drop_cnt+1 (saturating);
//    push and pop in same cycle when full are both accepted, level unchanged.
//  - FSM states IDLE, WAIT, RESP:
//      IDLE: FIFO non-empty -> pop into cur_addr, cnt=RESP_LAT-1, go WAIT.
//      WAIT: cnt==0 -> register Data=table[cur_addr], Valid_Data=1, go RESP; else cnt-1.
//      RESP: Valid_Data drops next edge; FIFO non-empty -> pop, reload cnt, go WAIT; else IDLE.
//  - Latency: request sampled at edge E0 into empty/IDLE block -> Valid_Data high after edge
//    E0+RESP_LAT+2, for one cycle. Sustained throughput one response per RESP_LAT+1 cycles.
//  - Responses strictly in request order; every accepted request produces exactly one response.
//  - Table read is read-before-write: cfg write to cur_addr on the Data-load edge returns old value.
//  - cfg writes are independent of FSM state and never stall it.
//  - FIFO pointers wrap modulo FIFO_DEPTH; level uses one extra bit to distinguish full/empty.
// STRUCTURE
//  - a_b_req_pkg: ADDR_W/DATA_W constants, resp_state_e {IDLE,WAIT,RESP}, addr_t/data_t typedefs.
//  - Sub-module b_req_fifo: sync FIFO (push/pop/full/empty/level), parameterised width/depth.
//  - Top: FSM, latency counter, table array (2**ADDR_W x DATA_W), drop counter, output regs.
// TESTING
//  1 Reset then write table[0x010]=0xABCDEF, single request 0x010 at E0 -> Valid_Data one
//    cycle after E0+4 (RESP_LAT=2), Data=0xABCDEF, busy returns 0.
//  2 8 back-to-back requests 0x000..0x007 (table[i]=i+0x100) -> 8 responses in order,
//    spaced 3 cycles, Data 0x100..0x107, drop_cnt=0.
//  3 12 back-to-back requests, FIFO_DEPTH=8 -> exactly the overflowing ones dropped per
//    push/pop rule, drop_cnt matches scoreboard, surviving responses in order.
//  4 cfg write table[0x020]=0x111111 on the Data-load edge of a pending 0x020 response
//    -> old value returned; next request 0x020 returns 0x111111.
//  5 Assert rst while in WAIT with 3 queued -> outputs zero immediately, no stray
//    Valid_Data after release, new request answered normally.
//  6 Force 300 drops -> drop_cnt saturates at 255, no wrap.

Source files
------------

// File: rtl/a_b_req_pkg.sv
// Shared widths, types and responder FSM states for the A->B request link.
package a_b_req_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 24;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } resp_state_e;

endpackage

// File: rtl/b_req_fifo.sv
// Synchronous request FIFO; a push into a full FIFO is accepted only when a pop happens on the same edge.
module b_req_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             do_push, do_pop;

    assign full    = (level_q == LVL_W'(DEPTH));
    assign empty   = (level_q == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem_q[rd_ptr_q];
    assign level   = level_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage carries data only, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/b_req_responder.sv
// Side-B responder: buffers requests from A, looks each up in a local table and answers in order
// after a fixed latency.
module b_req_responder #(
    parameter int ADDR_W     = a_b_req_pkg::ADDR_W,
    parameter int DATA_W     = a_b_req_pkg::DATA_W,
    parameter int FIFO_DEPTH = 8,
    parameter int RESP_LAT   = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          Valid_Addr,
    input  logic [ADDR_W-1:0]             Address,
    output logic                          Valid_Data,
    output logic [DATA_W-1:0]             Data,
    input  logic                          cfg_we,
    input  logic [ADDR_W-1:0]             cfg_addr,
    input  logic [DATA_W-1:0]             cfg_wdata,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [7:0]                    drop_cnt
);

    import a_b_req_pkg::*;

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int CNT_W = $clog2(RESP_LAT) + 1;

    resp_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic              req_vld_q;
    logic [ADDR_W-1:0] req_addr_q;
    logic              vld_q, vld_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [7:0]        drop_cnt_q, drop_cnt_d;
    logic [DATA_W-1:0] tbl_q [2**ADDR_W];

    logic              pop, full, empty, drop;
    logic [ADDR_W-1:0] head;
    logic [LVL_W-1:0]  level;

    b_req_fifo #(
        .WIDTH (ADDR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (req_vld_q),
        .pop   (pop),
        .din   (req_addr_q),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    assign drop = req_vld_q && full && !pop;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cur_addr_d = cur_addr_q;
        vld_d      = 1'b0;
        data_d     = data_q;
        pop        = 1'b0;
        drop_cnt_d = drop_cnt_q;
        if (drop && drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
        case (state_q)
            IDLE, RESP: begin
                if (!empty) begin
                    pop        = 1'b1;
                    cur_addr_d = head;
                    cnt_d      = CNT_W'(RESP_LAT - 1);
                    state_d    = WAIT;
                end else begin
                    state_d    = IDLE;
                end
            end
            WAIT: begin
                // Table read sees the pre-edge contents, so a same-edge cfg write returns old data.
                if (cnt_q == '0) begin
                    data_d  = tbl_q[cur_addr_q];
                    vld_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d   = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            req_vld_q  <= 1'b0;
            vld_q      <= 1'b0;
            data_q     <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_vld_q  <= Valid_Addr;
            vld_q      <= vld_d;
            data_q     <= data_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        req_addr_q <= Address;
        cur_addr_q <= cur_addr_d;
    end

    always_ff @(posedge clk) begin
        if (cfg_we) tbl_q[cfg_addr] <= cfg_wdata;
    end

    assign Valid_Data = vld_q;
    assign Data       = data_q;
    assign busy       = !empty || (state_q != IDLE);
    assign fifo_level = level;
    assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_b_req_responder.sv
// Bench for b_req_responder: timestamp/queue reference model compared every cycle, plus directed literal checks.
module tb_b_req_responder;

    localparam int AW    = 12;
    localparam int DW    = 24;
    localparam int DEPTH = 8;
    localparam int RL    = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          Valid_Addr;
    logic [AW-1:0] Address;
    logic          Valid_Data;
    logic [DW-1:0] Data;
    logic          cfg_we;
    logic [AW-1:0] cfg_addr;
    logic [DW-1:0] cfg_wdata;
    logic          busy;
    logic [3:0]    fifo_level;
    logic [7:0]    drop_cnt;

    b_req_responder #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .FIFO_DEPTH (DEPTH),
        .RESP_LAT   (RL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .Valid_Addr (Valid_Addr),
        .Address    (Address),
        .Valid_Data (Valid_Data),
        .Data       (Data),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_wdata  (cfg_wdata),
        .busy       (busy),
        .fifo_level (fifo_level),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: a request queue plus a single server that may start a new lookup
    // no earlier than next_free; each lookup answers RL edges after it starts.
    logic [DW-1:0] mtbl [4096];
    logic [AW-1:0] mq [$];
    bit            m_in_vld = 1'b0;
    logic [AW-1:0] m_in_addr = '0;
    longint        cyc = 0, next_free = 0, resp_time = 0;
    bit            resp_pend = 1'b0;
    logic [AW-1:0] resp_addr = '0;
    bit            e_vld = 1'b0;
    logic [DW-1:0] e_data = '0;
    int            e_drop = 0, e_level = 0;
    bit            e_busy = 1'b0;
    bit            m_pop, m_full;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            mq.delete();
            m_in_vld = 1'b0; cyc = 0; next_free = 0; resp_pend = 1'b0;
            e_vld = 1'b0; e_data = '0; e_drop = 0; e_level = 0; e_busy = 1'b0;
        end else begin
            m_full = (mq.size() == DEPTH);
            m_pop  = (mq.size() > 0) && (cyc >= next_free);
            e_vld  = 1'b0;
            if (resp_pend && resp_time == cyc) begin
                e_vld = 1'b1; e_data = mtbl[resp_addr]; resp_pend = 1'b0;
            end
            if (m_pop) begin
                resp_addr = mq.pop_front();
                resp_time = cyc + RL;
                resp_pend = 1'b1;
                next_free = cyc + RL + 1;
            end
            if (m_in_vld) begin
                if (m_full && !m_pop) begin
                    if (e_drop < 255) e_drop++;
                end else begin
                    mq.push_back(m_in_addr);
                end
            end
            m_in_vld  = Valid_Addr;
            m_in_addr = Address;
            if (cfg_we) mtbl[cfg_addr] = cfg_wdata;
            e_level = mq.size();
            e_busy  = (mq.size() > 0) || (cyc < next_free);
            cyc++;
        end
    end

    logic [DW-1:0] rsp_d [$];
    time           rsp_t [$];

    initial forever begin
        @(negedge clk);
        chk("valid", Valid_Data, e_vld);
        chk("data", Data, e_data);
        chk("busy", busy, e_busy);
        chk("level", fifo_level, e_level);
        chk("drop_cnt", drop_cnt, e_drop);
        if (Valid_Data === 1'b1) begin
            rsp_d.push_back(Data);
            rsp_t.push_back($time);
        end
    end

    logic [DW-1:0] wr_tbl [4096];
    logic [AW-1:0] a3 [20];
    int            lat;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic cfg_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d; wr_tbl[a] = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic send(input logic [AW-1:0] a);
        Valid_Addr = 1'b1; Address = a;
        tick();
        Valid_Addr = 1'b0;
    endtask

    task automatic wait_resp(output int k);
        k = 0;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk);
            #1;
            if (Valid_Data === 1'b1) begin
                k = i;
                break;
            end
        end
    endtask

    task automatic clear_rsp();
        rsp_d.delete();
        rsp_t.delete();
    endtask

    initial begin
        rst = 1'b1; Valid_Addr = 1'b0; Address = '0;
        cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_valid", Valid_Data, 0);
        chk("rst_data", Data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_drop", drop_cnt, 0);

        cfg_write(12'h010, 24'hABCDEF);
        for (int i = 0; i < 8; i++) cfg_write(AW'(i), DW'(32'h100 + i));
        cfg_write(12'h020, 24'h222222);
        for (int i = 64; i < 128; i++) cfg_write(AW'(i), DW'($urandom));

        // Single request into an idle block.
        send(12'h010);
        wait_resp(lat);
        chk("t1_latency", lat, 4);
        chk("t1_data", Data, 24'hABCDEF);
        tick();
        chk("t1_valid_drop", Valid_Data, 0);
        chk("t1_busy_idle", busy, 0);

        // Eight back-to-back requests.
        clear_rsp();
        for (int i = 0; i < 8; i++) send(AW'(i));
        repeat (40) tick();
        chk("t2_count", rsp_d.size(), 8);
        for (int i = 0; i < 8 && i < rsp_d.size(); i++) begin
            chk("t2_data", rsp_d[i], 32'h100 + i);
            if (i > 0) chk("t2_spacing", 32'((rsp_t[i] - rsp_t[i-1]) / 10), 3);
        end
        chk("t2_drop", drop_cnt, 0);

        // Twelve back-to-back: occupancy peaks at exactly DEPTH, nothing dropped.
        clear_rsp();
        for (int i = 0; i < 12; i++) begin
            a3[i] = AW'($urandom_range(64, 127));
            send(a3[i]);
        end
        repeat (60) tick();
        chk("t3a_drop", drop_cnt, 0);
        chk("t3a_count", rsp_d.size(), 12);
        for (int i = 0; i < 12 && i < rsp_d.size(); i++) chk("t3a_data", rsp_d[i], wr_tbl[a3[i]]);

        // Twenty back-to-back: requests 12,14,15,17,18 arrive at a full FIFO with no pop.
        clear_rsp();
        for (int i = 0; i < 20; i++) begin
            a3[i] = AW'($urandom_range(64, 127));
            send(a3[i]);
        end
        repeat (70) tick();
        chk("t3b_drop", drop_cnt, 5);
        chk("t3b_count", rsp_d.size(), 15);
        begin
            int j;
            j = 0;
            for (int i = 0; i < 20; i++) begin
                if (i == 12 || i == 14 || i == 15 || i == 17 || i == 18) continue;
                if (j < rsp_d.size()) chk("t3b_data", rsp_d[j], wr_tbl[a3[i]]);
                j++;
            end
        end

        // cfg write lands on the Data-load edge of a pending 0x020 lookup.
        send(12'h020);
        repeat (3) tick();
        cfg_we = 1'b1; cfg_addr = 12'h020; cfg_wdata = 24'h111111;
        tick();
        cfg_we = 1'b0;
        wr_tbl[12'h020] = 24'h111111;
        chk("t4_valid", Valid_Data, 1);
        chk("t4_old_data", Data, 24'h222222);
        repeat (3) tick();
        send(12'h020);
        wait_resp(lat);
        chk("t4_new_data", Data, 24'h111111);
        repeat (3) tick();

        // Reset while waiting with three requests queued.
        for (int i = 0; i < 5; i++) send(AW'(i));
        repeat (2) tick();
        chk("t5_pre_level", fifo_level, 3);
        chk("t5_pre_busy", busy, 1);
        rst = 1'b1;
        #1;
        chk("t5_rst_valid", Valid_Data, 0);
        chk("t5_rst_data", Data, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_level", fifo_level, 0);
        chk("t5_rst_drop", drop_cnt, 0);
        repeat (2) tick();
        rst = 1'b0;
        clear_rsp();
        repeat (15) tick();
        chk("t5_no_stray", rsp_d.size(), 0);
        send(12'h010);
        wait_resp(lat);
        chk("t5_latency", lat, 4);
        chk("t5_data", Data, 24'hABCDEF);
        repeat (3) tick();

        // Sustained overflow well past 255 drops.
        Valid_Addr = 1'b1;
        for (int i = 0; i < 500; i++) begin
            Address = AW'($urandom_range(64, 127));
            tick();
        end
        Valid_Addr = 1'b0;
        chk("t6_drop_sat", drop_cnt, 255);
        repeat (40) tick();
        chk("t6_drain_busy", busy, 0);
        chk("t6_drop_hold", drop_cnt, 255);

        // Random traffic with interleaved table writes.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 400; i++) begin
            Valid_Addr = ($urandom_range(0, 9) < 4);
            Address    = AW'($urandom_range(64, 127));
            cfg_we     = ($urandom_range(0, 7) == 0);
            cfg_addr   = AW'($urandom_range(64, 127));
            cfg_wdata  = DW'($urandom);
            tick();
        end
        Valid_Addr = 1'b0;
        cfg_we = 1'b0;
        repeat (50) tick();
        chk("rand_idle", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete, got running, required finished");
        $fatal(1, "timeout");
    end

endmodule
